mem_line_refill: RTL and testbench

Line-level front end for the external memory port, between the cache miss logic and the external memory. It converts one cache-line request into the memory's beat protocol: an optional 4-beat dirty-victim writeback, then an optional 4-beat line fill. Each line is 4 × `MEM_DATA_BITS` (512 bits). Fill beats are collected into a line buffer and returned to the cache as a single 512-bit response.

---
 rtl/mem_line_refill.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_line_refill.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_refill.sv
// -----------------------------------------------------------------------------
// mem_line_refill
//
// Line-level front end for the external memory port. Turns one cache-line
// request into the memory beat protocol: an optional 4-beat dirty-victim
// writeback (address beat, then data beat, per memory word), followed by an
// optional 4-beat line fill. Fill beats are gathered into a line buffer and
// returned to the cache as a single 4*MEM_DATA_BITS response.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   line_req_*            cache request channel (valid/ready, fill line address,
//                         fill/dirty flags, victim line address and data)
//   line_resp_valid/data  one-cycle completion pulse; filled line (beat k at
//                         bits [k*MEM_DATA_BITS +: MEM_DATA_BITS])
//   mem_req_*             memory address channel (valid/ready, rw, addr, tag)
//   mem_req_data_*        memory write-data channel (valid/ready, bits, mask)
//   mem_resp_*            memory read-response channel (valid, data, tag)
// -----------------------------------------------------------------------------
module mem_line_refill #(
   parameter int unsigned             MEM_ADDR_BITS = 32,
   parameter int unsigned             MEM_DATA_BITS = 128,
   parameter int unsigned             MEM_TAG_BITS  = 5,
   parameter logic [MEM_TAG_BITS-1:0] REQ_TAG       = '0
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic                         line_req_valid,
   output logic                         line_req_ready,
   input  logic [MEM_ADDR_BITS-3:0]     line_req_addr,
   input  logic                         line_req_fill,
   input  logic                         line_req_dirty,
   input  logic [MEM_ADDR_BITS-3:0]     line_req_wb_addr,
   input  logic [4*MEM_DATA_BITS-1:0]   line_req_wb_data,

   output logic                         line_resp_valid,
   output logic [4*MEM_DATA_BITS-1:0]   line_resp_data,

   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_rw,
   output logic [MEM_ADDR_BITS-1:0]     mem_req_addr,
   output logic [MEM_TAG_BITS-1:0]      mem_req_tag,

   output logic                         mem_req_data_valid,
   input  logic                         mem_req_data_ready,
   output logic [MEM_DATA_BITS-1:0]     mem_req_data_bits,
   output logic [MEM_DATA_BITS/8-1:0]   mem_req_data_mask,

   input  logic                         mem_resp_valid,
   input  logic [MEM_DATA_BITS-1:0]     mem_resp_data,
   input  logic [MEM_TAG_BITS-1:0]      mem_resp_tag
);

   localparam int unsigned LINE_ADDR_BITS = MEM_ADDR_BITS - 2;
   localparam int unsigned LINE_BITS      = 4 * MEM_DATA_BITS;

   typedef enum logic [2:0] {
      StIdle,
      StWbAddr,
      StWbData,
      StRdAddr,
      StRdData,
      StResp
   } state_e;

   state_e                    state_q, state_d;
   logic [1:0]                beat_q, beat_d;
   logic [LINE_ADDR_BITS-1:0] line_addr_q, line_addr_d;
   logic [LINE_ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
   logic [LINE_BITS-1:0]      wb_data_q, wb_data_d;
   logic [LINE_BITS-1:0]      buf_q, buf_d;
   logic                      fill_q, fill_d;

   // Only responses carrying our tag count as fill beats.
   logic resp_hit;
   assign resp_hit = mem_resp_valid && (mem_resp_tag == REQ_TAG);

   // The buffer is held until the next fill overwrites it.
   assign line_resp_data = buf_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      line_addr_d = line_addr_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      buf_d       = buf_q;
      fill_d      = fill_q;

      case (state_q)
         StIdle: begin
            if (line_req_valid) begin
               line_addr_d = line_req_addr;
               wb_addr_d   = line_req_wb_addr;
               wb_data_d   = line_req_wb_data;
               fill_d      = line_req_fill;
               beat_d      = 2'd0;
               if (line_req_dirty) begin
                  state_d = StWbAddr;
               end else if (line_req_fill) begin
                  state_d = StRdAddr;
               end else begin
                  state_d = StResp;
               end
            end
         end

         StWbAddr: begin
            if (mem_req_ready) begin
               state_d = StWbData;
            end
         end

         StWbData: begin
            if (mem_req_data_ready) begin
               // Wraps 3 -> 0, leaving the counter cleared for the fill phase.
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_d = fill_q ? StRdAddr : StResp;
               end else begin
                  state_d = StWbAddr;
               end
            end
         end

         StRdAddr: begin
            beat_d = 2'd0;
            if (mem_req_ready) begin
               state_d = StRdData;
            end
         end

         StRdData: begin
            if (resp_hit) begin
               buf_d[beat_q*MEM_DATA_BITS +: MEM_DATA_BITS] = mem_resp_data;
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_d = StResp;
               end
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs: pure decodes of registered state, so they cannot change while a
   // handshake is stalled.
   // ---------------------------------------------------------------------------
   always_comb begin
      line_req_ready     = 1'b0;
      line_resp_valid    = 1'b0;
      mem_req_valid      = 1'b0;
      mem_req_rw         = 1'b0;
      mem_req_addr       = '0;
      mem_req_tag        = '0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = '0;
      mem_req_data_mask  = '0;

      case (state_q)
         StIdle: begin
            line_req_ready = 1'b1;
         end

         StWbAddr: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {wb_addr_q, beat_q};
            mem_req_tag   = REQ_TAG;
         end

         StWbData: begin
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = wb_data_q[beat_q*MEM_DATA_BITS +: MEM_DATA_BITS];
            mem_req_data_mask  = '1;
         end

         StRdAddr: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {line_addr_q, 2'b00};
            mem_req_tag   = REQ_TAG;
         end

         StResp: begin
            line_resp_valid = 1'b1;
         end

         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         beat_q      <= 2'd0;
         line_addr_q <= '0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         buf_q       <= '0;
         fill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         line_addr_q <= line_addr_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         buf_q       <= buf_d;
         fill_q      <= fill_d;
      end
   end

endmodule

// File: tb/tb_mem_line_refill.sv
// -----------------------------------------------------------------------------
// tb_mem_line_refill
//
// Self-checking bench for mem_line_refill. A word-addressed memory model
// answers the DUT's beat traffic with planned stalls, response gaps, foreign
// tagged beats and stray responses. A separate reference memory is updated at
// line granularity from each request; expected latency is derived from the
// cycle cost of each phase plus the planned stalls.
// -----------------------------------------------------------------------------
module tb_mem_line_refill;

   localparam int unsigned AW  = 10;
   localparam int unsigned DW  = 128;
   localparam int unsigned TW  = 4;
   localparam int unsigned LA  = AW - 2;
   localparam logic [TW-1:0] TAG = 4'h5;

   logic            clk;
   logic            reset;
   logic            line_req_valid;
   logic            line_req_ready;
   logic [LA-1:0]   line_req_addr;
   logic            line_req_fill;
   logic            line_req_dirty;
   logic [LA-1:0]   line_req_wb_addr;
   logic [4*DW-1:0] line_req_wb_data;
   logic            line_resp_valid;
   logic [4*DW-1:0] line_resp_data;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_rw;
   logic [AW-1:0]   mem_req_addr;
   logic [TW-1:0]   mem_req_tag;
   logic            mem_req_data_valid;
   logic            mem_req_data_ready;
   logic [DW-1:0]   mem_req_data_bits;
   logic [DW/8-1:0] mem_req_data_mask;
   logic            mem_resp_valid;
   logic [DW-1:0]   mem_resp_data;
   logic [TW-1:0]   mem_resp_tag;

   mem_line_refill #(
      .MEM_ADDR_BITS (AW),
      .MEM_DATA_BITS (DW),
      .MEM_TAG_BITS  (TW),
      .REQ_TAG       (TAG)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .line_req_valid     (line_req_valid),
      .line_req_ready     (line_req_ready),
      .line_req_addr      (line_req_addr),
      .line_req_fill      (line_req_fill),
      .line_req_dirty     (line_req_dirty),
      .line_req_wb_addr   (line_req_wb_addr),
      .line_req_wb_data   (line_req_wb_data),
      .line_resp_valid    (line_resp_valid),
      .line_resp_data     (line_resp_data),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_rw         (mem_req_rw),
      .mem_req_addr       (mem_req_addr),
      .mem_req_tag        (mem_req_tag),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data),
      .mem_resp_tag       (mem_resp_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   logic [DW-1:0] mem     [1024];  // memory the DUT talks to
   logic [DW-1:0] ref_mem [1024];  // line-level reference

   // Per-transaction plan: stall cycles per handshake, gap cycles before each
   // fill beat, whether gaps carry foreign-tag beats, stray responses enabled.
   int wb_as [4];
   int wb_ds [4];
   int rd_as;
   int gp    [4];
   bit bogus;
   bit stray_en;

   logic [LA-1:0]   cur_la, cur_wa;
   logic [4*DW-1:0] cur_victim;
   logic            cur_fill, cur_dirty;
   int              widx_a, widx_d, n_reads;
   int              as_left, ds_left, rs_left, gap_left, rbeat;
   bit              rd_pending;
   logic [LA-1:0]   rd_line;
   logic [AW-1:0]   pend_waddr;
   logic [4*DW-1:0] last_fill;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [4*DW-1:0] rand_line();
      return {rand_word(), rand_word(), rand_word(), rand_word()};
   endfunction

   task automatic plan_zero();
      for (int k = 0; k < 4; k++) begin
         wb_as[k] = 0;
         wb_ds[k] = 0;
         gp[k]    = 0;
      end
      rd_as    = 0;
      bogus    = 1'b0;
      stray_en = 1'b0;
   endtask

   task automatic plan_random();
      for (int k = 0; k < 4; k++) begin
         wb_as[k] = int'($urandom_range(0, 2));
         wb_ds[k] = int'($urandom_range(0, 2));
         gp[k]    = int'($urandom_range(0, 2));
      end
      rd_as    = int'($urandom_range(0, 3));
      bogus    = 1'($urandom_range(0, 1));
      stray_en = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 512'(line_req_ready), 512'(1'b1));
      check_eq({tag, "_valids"}, 512'({line_resp_valid, mem_req_valid, mem_req_data_valid,
                                       mem_req_rw}), 512'(0));
      check_eq({tag, "_addr_tag_mask"}, 512'({mem_req_addr, mem_req_tag, mem_req_data_mask}),
               512'(0));
      check_eq({tag, "_wdata"}, 512'(mem_req_data_bits), 512'(0));
      check_eq({tag, "_line"}, 512'(line_resp_data), 512'(0));
   endtask

   // One memory-side cycle, called at the falling edge: observe the DUT and
   // drive the memory inputs for the coming rising edge.
   task automatic mem_cycle();
      mem_resp_valid = 1'b0;
      mem_resp_tag   = TAG;
      mem_resp_data  = rand_word();
      if (rd_pending) begin
         if (gap_left > 0) begin
            gap_left--;
            if (bogus) begin
               mem_resp_valid = 1'b1;
               mem_resp_tag   = TAG ^ 4'h3;
            end
         end else begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem[{rd_line, 2'(rbeat)}];
            rbeat++;
            if (rbeat == 4) rd_pending = 1'b0;
            else gap_left = gp[rbeat];
         end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
         mem_resp_valid = 1'b1;
      end

      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
         check_eq("req_tag", 512'(mem_req_tag), 512'(TAG));
         check_eq("addr_data_overlap", 512'(mem_req_data_valid), 512'(1'b0));
         if (mem_req_rw) begin
            check_eq("wb_addr", 512'(mem_req_addr), 512'({cur_wa, 2'(widx_a)}));
            check_eq("wb_allowed", 512'(cur_dirty && widx_a < 4 && widx_a == widx_d), 512'(1'b1));
            if (as_left > 0) begin
               as_left--;
            end else begin
               mem_req_ready = 1'b1;
               pend_waddr    = mem_req_addr;
               widx_a++;
               if (widx_a < 4) as_left = wb_as[widx_a];
            end
         end else begin
            check_eq("rd_addr", 512'(mem_req_addr), 512'({cur_la, 2'b00}));
            check_eq("rd_order", 512'(cur_fill && n_reads == 0 && widx_d == (cur_dirty ? 4 : 0)),
                     512'(1'b1));
            if (rs_left > 0) begin
               rs_left--;
            end else begin
               mem_req_ready = 1'b1;
               n_reads++;
               rd_pending = 1'b1;
               rd_line    = mem_req_addr[AW-1:2];
               rbeat      = 0;
               gap_left   = gp[0];
            end
         end
      end

      mem_req_data_ready = 1'b0;
      if (mem_req_data_valid) begin
         check_eq("wb_data", 512'(mem_req_data_bits),
                  512'(widx_d < 4 ? cur_victim[widx_d*DW +: DW] : '0));
         check_eq("wb_mask", 512'(mem_req_data_mask), 512'({(DW/8){1'b1}}));
         check_eq("wb_seq", 512'(widx_a == widx_d + 1), 512'(1'b1));
         if (ds_left > 0) begin
            ds_left--;
         end else begin
            mem_req_data_ready = 1'b1;
            mem[pend_waddr]    = mem_req_data_bits;
            widx_d++;
            if (widx_d < 4) ds_left = wb_ds[widx_d];
         end
      end
   endtask

   // Issue one line request; abort_beat >= 0 pulls reset while the DUT offers
   // that writeback data beat. lat is the accept-to-response cycle count.
   task automatic run_txn(input logic [LA-1:0] la, input logic fill, input logic dirty,
                          input logic [LA-1:0] wa, input logic [4*DW-1:0] victim,
                          input int abort_beat, output int lat);
      int              exp_lat;
      int              budget;
      bit              done;
      logic [4*DW-1:0] exp_line;
      logic [4*DW-1:0] got_wb, exp_wb;

      lat        = -1;
      done       = 1'b0;
      cur_la     = la;
      cur_wa     = wa;
      cur_victim = victim;
      cur_fill   = fill;
      cur_dirty  = dirty;
      widx_a     = 0;
      widx_d     = 0;
      n_reads    = 0;
      as_left    = wb_as[0];
      ds_left    = wb_ds[0];
      rs_left    = rd_as;
      rd_pending = 1'b0;

      // Cost: 1 to leave idle, 2 per writeback word, 1 read address, 4 beats.
      exp_lat = 1;
      if (dirty) for (int k = 0; k < 4; k++) exp_lat += 2 + wb_as[k] + wb_ds[k];
      if (fill) begin
         exp_lat += 5 + rd_as;
         for (int k = 0; k < 4; k++) exp_lat += gp[k];
      end

      // The writeback lands before the fill reads, so a self-refill sees it.
      if (dirty) begin
         for (int k = 0; k < 4; k++) begin
            if (abort_beat < 0 || k < abort_beat) ref_mem[{wa, 2'(k)}] = victim[k*DW +: DW];
         end
      end
      for (int k = 0; k < 4; k++) exp_line[k*DW +: DW] = ref_mem[{la, 2'(k)}];

      budget = 0;
      do begin
         @(negedge clk);
         mem_cycle();
         budget++;
      end while (!line_req_ready && budget < 50);
      check_eq("idle_ready", 512'(line_req_ready), 512'(1'b1));
      if (!line_req_ready) return;

      line_req_valid   = 1'b1;
      line_req_addr    = la;
      line_req_fill    = fill;
      line_req_dirty   = dirty;
      line_req_wb_addr = wa;
      line_req_wb_data = victim;

      for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
         @(negedge clk);
         if (abort_beat >= 0 && mem_req_data_valid && widx_d == abort_beat) begin
            mem_req_ready      = 1'b0;
            mem_req_data_ready = 1'b0;
            mem_resp_valid     = 1'b0;
            line_req_valid     = 1'b0;
            #2 reset = 1'b0;
            #1 check_reset_outputs("abort");
            rd_pending = 1'b0;
            last_fill  = '0;
            for (int k = 0; k < 4; k++) begin
               got_wb[k*DW +: DW] = mem[{wa, 2'(k)}];
               exp_wb[k*DW +: DW] = ref_mem[{wa, 2'(k)}];
            end
            check_eq("abort_mem", got_wb, exp_wb);
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         check_eq("busy_ready", 512'(line_req_ready), 512'(1'b0));
         if (line_resp_valid) begin
            lat            = cyc;
            done           = 1'b1;
            line_req_valid = 1'b0;
         end else begin
            // Junk requests while busy must be ignored.
            line_req_valid   = 1'($urandom_range(0, 1));
            line_req_addr    = LA'($urandom);
            line_req_fill    = 1'($urandom);
            line_req_dirty   = 1'($urandom);
            line_req_wb_addr = LA'($urandom);
            line_req_wb_data = rand_line();
         end
         mem_cycle();
      end

      check_eq("latency", 512'(lat), 512'(exp_lat));
      @(negedge clk);
      mem_cycle();
      check_eq("resp_pulse", 512'(line_resp_valid), 512'(1'b0));
      check_eq("ready_after", 512'(line_req_ready), 512'(1'b1));
      if (fill) begin
         check_eq("line_data", line_resp_data, exp_line);
         last_fill = exp_line;
      end else begin
         check_eq("line_hold", line_resp_data, last_fill);
      end
      check_eq("n_reads", 512'(n_reads), 512'(fill ? 1 : 0));
      check_eq("n_writes", 512'(widx_d), 512'(dirty ? 4 : 0));
      if (dirty) begin
         for (int k = 0; k < 4; k++) begin
            got_wb[k*DW +: DW] = mem[{wa, 2'(k)}];
            exp_wb[k*DW +: DW] = ref_mem[{wa, 2'(k)}];
         end
         check_eq("wb_mem", got_wb, exp_wb);
      end
   endtask

   logic [4*DW-1:0] a_line, d_line;
   int              lat;

   initial begin
      n_tests            = 0;
      n_fail             = 0;
      reset              = 1'b1;
      line_req_valid     = 1'b0;
      line_req_addr      = '0;
      line_req_fill      = 1'b0;
      line_req_dirty     = 1'b0;
      line_req_wb_addr   = '0;
      line_req_wb_data   = '0;
      mem_req_ready      = 1'b0;
      mem_req_data_ready = 1'b0;
      mem_resp_valid     = 1'b0;
      mem_resp_data      = '0;
      mem_resp_tag       = '0;
      last_fill          = '0;
      rd_pending         = 1'b0;
      plan_zero();
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = rand_word();
         ref_mem[i] = mem[i];
      end
      a_line = rand_line();
      d_line = rand_line();
      for (int k = 0; k < 4; k++) begin
         mem[10'h100 + k]     = a_line[k*DW +: DW];
         ref_mem[10'h100 + k] = a_line[k*DW +: DW];
      end

      #2 reset = 1'b0;
      #1 check_reset_outputs("por");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Clean fill, zero-stall memory.
      plan_zero();
      run_txn(8'h40, 1'b1, 1'b0, 8'h00, '0, -1, lat);
      check_eq("clean_lat", 512'(lat), 512'(6));
      check_eq("clean_line", line_resp_data, a_line);

      // Dirty fill: victim 0x20 to words 0x80..0x83, then fill 0x40.
      run_txn(8'h40, 1'b1, 1'b1, 8'h20, d_line, -1, lat);
      check_eq("dirty_lat", 512'(lat), 512'(14));
      check_eq("dirty_mem82", 512'(mem[10'h082]), 512'(d_line[2*DW +: DW]));

      // Writeback only.
      run_txn(8'h11, 1'b0, 1'b1, 8'h33, rand_line(), -1, lat);
      check_eq("wbonly_lat", 512'(lat), 512'(9));

      // Neither fill nor dirty.
      run_txn(8'h12, 1'b0, 1'b0, 8'h34, rand_line(), -1, lat);
      check_eq("none_lat", 512'(lat), 512'(1));

      // Back-pressure: 5 address-stall cycles, 3 data-stall cycles.
      plan_zero();
      wb_as[0] = 2;
      rd_as    = 3;
      wb_ds[2] = 3;
      run_txn(8'h40, 1'b1, 1'b1, 8'h21, rand_line(), -1, lat);
      check_eq("bp_lat", 512'(lat), 512'(22));

      // Foreign-tag beat between fill beats 1 and 2.
      plan_zero();
      gp[2] = 1;
      bogus = 1'b1;
      run_txn(8'h40, 1'b1, 1'b0, 8'h00, '0, -1, lat);
      check_eq("tag_line", line_resp_data, a_line);

      // Reset during the third writeback data beat, then a clean fill.
      plan_zero();
      run_txn(8'h40, 1'b1, 1'b1, 8'h22, rand_line(), 2, lat);
      run_txn(8'h40, 1'b1, 1'b0, 8'h00, '0, -1, lat);
      check_eq("post_reset_lat", 512'(lat), 512'(6));
      check_eq("post_reset_line", line_resp_data, a_line);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         plan_random();
         run_txn(LA'($urandom), 1'($urandom), 1'($urandom), LA'($urandom), rand_line(), -1, lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
